// File: rtl/mmio_stream_port.sv
// mmio_stream_port: memory-mapped streaming port on the CPU data bus.
// Four word registers at BASE_ADDR: TXDATA, RXDATA, STATUS and CONTROL.
// TXDATA feeds an outbound valid/ready stream. An inbound stream fills RXDATA.
// A level interrupt reports TX empty and/or RX data available.
// Optional macro MMIO_LOOPBACK_EN adds CONTROL[3] loopback (TX head -> RX tail).
module mmio_stream_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int unsigned DEPTH     = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic [63:0] i_wr_data,
    input  logic        i_write_enable,
    input  logic        i_read_enable,
    output logic [63:0] o_rd_data,
    output logic        o_hit,
    output logic [63:0] o_out_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    input  logic [63:0] i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [63:0]   r_tx_mem [DEPTH];
    logic [63:0]   r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [CW-1:0] r_tx_count, r_rx_count;

    // Sticky flags and control
    logic r_tx_overflow, r_rx_underflow;
    logic r_tx_irq_en, r_rx_irq_en;
    logic w_loopback;

    // Decode
    logic [31:0] w_offset;
    logic        w_tx_wr, w_rx_rd, w_ctrl_wr;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_lb_move;
    logic [63:0] w_status, w_control;

    // Offset subtraction keeps the range check correct even near the top of the map
    assign w_offset  = i_addr - BASE_ADDR;
    assign o_hit     = (w_offset < 32'd4);
    assign w_tx_wr   = o_hit & i_write_enable & (w_offset[1:0] == 2'd0);
    assign w_rx_rd   = o_hit & i_read_enable & (w_offset[1:0] == 2'd1);
    assign w_ctrl_wr = o_hit & i_write_enable & (w_offset[1:0] == 2'd3);

    assign w_tx_full  = (r_tx_count == FULL_CNT);
    assign w_tx_empty = (r_tx_count == '0);
    assign w_rx_full  = (r_rx_count == FULL_CNT);
    assign w_rx_empty = (r_rx_count == '0);

    // Loopback owns both stream ends while enabled
    assign w_lb_move = w_loopback & ~w_tx_empty & ~w_rx_full;

    assign o_out_valid = ~w_tx_empty & ~w_loopback & ~i_reset;
    assign o_out_data  = r_tx_mem[r_tx_rptr];
    assign o_in_ready  = ~w_rx_full & ~w_loopback & ~i_reset;

    assign w_tx_push = w_tx_wr & ~w_tx_full;
    assign w_tx_pop  = (o_out_valid & i_out_ready) | w_lb_move;
    assign w_rx_push = (i_in_valid & o_in_ready) | w_lb_move;
    assign w_rx_pop  = w_rx_rd & ~w_rx_empty;

    assign o_irq = (r_tx_irq_en & w_tx_empty) | (r_rx_irq_en & ~w_rx_empty);

    assign w_status = {40'd0, 8'(r_rx_count), 8'(r_tx_count), 2'b00,
                       r_rx_underflow, r_tx_overflow,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
    assign w_control = {60'd0, w_loopback, 1'b0, r_rx_irq_en, r_tx_irq_en};

    // Read mux: combinational from address and registered state
    always_comb begin
        o_rd_data = 64'd0;
        if (o_hit) begin
            unique case (w_offset[1:0])
                2'd0: o_rd_data = 64'd0;
                2'd1: o_rd_data = w_rx_empty ? 64'd0 : r_rx_mem[r_rx_rptr];
                2'd2: o_rd_data = w_status;
                2'd3: o_rd_data = w_control;
                default: o_rd_data = 64'd0;
            endcase
        end
    end

    // FIFO data arrays; contents need no reset since pointers define validity
    always_ff @(posedge i_clock) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= i_wr_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= w_loopback ? r_tx_mem[r_tx_rptr] : i_in_data;
        end
    end

    // Pointers and occupancy counts for both FIFOs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            r_tx_count <= r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);
            r_rx_count <= r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    // Sticky error flags and CONTROL; a new error on the clearing edge stays set
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
            r_tx_irq_en    <= 1'b0;
            r_rx_irq_en    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_tx_irq_en <= i_wr_data[0];
                r_rx_irq_en <= i_wr_data[1];
                if (i_wr_data[2]) begin
                    r_tx_overflow  <= 1'b0;
                    r_rx_underflow <= 1'b0;
                end
            end
            if (w_tx_wr & w_tx_full) r_tx_overflow <= 1'b1;
            if (w_rx_rd & w_rx_empty) r_rx_underflow <= 1'b1;
        end
    end

`ifdef MMIO_LOOPBACK_EN
    logic r_loopback;

    // Loopback enable bit, CONTROL[3]
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_loopback <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_loopback <= i_wr_data[3];
        end
    end

    assign w_loopback = r_loopback;
`else
    assign w_loopback = 1'b0;
`endif

endmodule

// File: doc/mmio_stream_port.md
Name: mmio_stream_port

Overview:
- Memory-mapped responder on the CPU data bus: the slave end of the CPU's address/data/write-enable/read-enable path, decoded alongside RAM.
- Four word registers at BASE_ADDR: outbound FIFO (CPU writes, streamed out via valid/ready), inbound FIFO (streamed in, CPU reads), status, control.
- Drives an interrupt request.
- Gives programs a buffered I/O channel without stalling the single-cycle bus.

Parameters:
- BASE_ADDR, 32'h0000_0100, word address of offset 0; decode covers BASE_ADDR..BASE_ADDR+3.
- DEPTH, 8, entries per FIFO; power of two, 2..128.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- addr  input  32  word address from the CPU bus
- wr_data  input  64  CPU write data
- write_enable  input  1  CPU write strobe
- read_enable  input  1  CPU read strobe (gates side effects only)
- rd_data  output  64  read data; combinational from addr
- hit  output  1  addr within BASE_ADDR..BASE_ADDR+3
- out_data  output  64  outbound FIFO head
- out_valid  output  1  outbound FIFO not empty
- out_ready  input  1  consumer accepts out_data
- in_data  input  64  inbound word
- in_valid  input  1  producer offers in_data
- in_ready  output  1  inbound FIFO can accept
- irq  output  1  level interrupt

Behaviour:
- Offsets:
  - 0 TXDATA: write pushes; read returns 0.
  - 1 RXDATA: read returns RX head, or 0 if empty; read with read_enable pops.
  - 2 STATUS: read-only.
  - 3 CONTROL: read/write.
- Side effects require hit. Writes to STATUS are ignored; rd_data=0 when hit=0.
- STATUS bits:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty
  - [4] tx_overflow (sticky), [5] rx_underflow (sticky)
  - [15:8] tx_count, [23:16] rx_count
  - all other bits 0
- CONTROL bits:
  - [0] tx_irq_en, [1] rx_irq_en: stored.
  - [2] clear: write 1 clears both sticky flags that edge; not stored, reads 0.
  - [3] loopback: see Optional Feature.
  - other bits ignore writes and read 0.
- TX push:
  - write_enable & addr==offset0 & !tx_full at the edge → entry stored, tx_count+1 next cycle.
  - If tx_full at that edge, the write is dropped and tx_overflow is set, even if a pop occurs the same cycle.
- TX pop: out_valid & out_ready at the edge. Push and pop in the same cycle (not full) leave the count unchanged and preserve order.
- RX push: in_valid & in_ready. in_ready = !rx_full & !reset.
- RX pop:
  - read_enable & addr==offset1 & !rx_empty.
  - If rx_empty, the read returns 0, rx_underflow is set, and pointers do not move.
  - Simultaneous push and pop are both honoured.
- Pointers: (log2 DEPTH)-bit wrap-around; counts are (log2 DEPTH)+1 bits, zero-extended into their status fields.
- Latency: a pushed word is visible at out_data/RX head the cycle after the push edge. Status reflects state after the last edge.
- irq = (tx_irq_en & tx_empty) | (rx_irq_en & !rx_empty); combinational from registered state.
- Reset values:
  - FIFOs empty, counts 0, sticky flags 0, CONTROL 0.
  - out_valid=0, in_ready=0 while reset is high, irq=0, rd_data per addr with reset state.
  - A reset mid-stream discards all buffered data.

Optional Feature:
- Macro MMIO_LOOPBACK_EN.
- Defined:
  - CONTROL[3] is stored.
  - When set: out_valid=0, in_ready=0, and each cycle TX head moves to RX tail if !tx_empty & !rx_full.
  - CPU accesses behave normally.
- Undefined: CONTROL[3] reads 0, writes are ignored, and no loopback path exists.

Test Plan:
- Reset, then read STATUS (addr BASE+2) → rd_data=64'h0000_0000_0000_000A (tx_empty, rx_empty), out_valid=0, in_ready=1, irq=0.
- Write 64'hDEAD_BEEF_0000_0001 to BASE+0 with out_ready=0 → next cycle out_valid=1, out_data=DEAD_BEEF_0000_0001, tx_count=1; assert out_ready → out_valid=0 the following cycle.
- With out_ready=0, push 9 words (DEPTH=8) → tx_full=1, tx_count=8, tx_overflow=1, 9th word absent; write CONTROL=4 → tx_overflow=0.
- Drive in_data=1..8 with in_valid=1 → in_ready=0 after 8th; CPU reads BASE+1 ×8 returning 1..8 in order; 9th read returns 0 and sets rx_underflow.
- CONTROL=2, push one RX word → irq=1; read RXDATA → irq=0 next cycle. CONTROL=1 with TX empty → irq=1.
- With MMIO_LOOPBACK_EN, CONTROL=8, write 5 to TXDATA → out_valid stays 0; after ≤2 cycles RXDATA reads 5 and rx_count=1. Without the macro, CONTROL reads 0.
